// File: rtl/alu_pkg.sv
// Shared definitions for the execute controller and the ALU.
//   - opcode and condition encodings
//   - NZCV flag bit indices
//   - cond_eval(): condition table shared with the ALU condition logic
//   - writes_rf(): opcodes that retire with a register-file write
//   - state_t: execute-controller FSM states
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_ORR = 4'b0011;
    localparam logic [3:0] OP_EOR = 4'b0100;
    localparam logic [3:0] OP_MOV = 4'b0101;
    localparam logic [3:0] OP_LSL = 4'b0110;
    localparam logic [3:0] OP_ROR = 4'b0111;
    localparam logic [3:0] OP_CMP = 4'b1000;
    localparam logic [3:0] OP_LDR = 4'b1001;
    localparam logic [3:0] OP_STR = 4'b1010;
    localparam logic [3:0] OP_NOP = 4'b1111;

    localparam logic [3:0] COND_AL   = 4'b0000;
    localparam logic [3:0] COND_EQ   = 4'b0001;
    localparam logic [3:0] COND_GT   = 4'b0010;
    localparam logic [3:0] COND_LTNE = 4'b0011;
    localparam logic [3:0] COND_GE   = 4'b0100;
    localparam logic [3:0] COND_LT   = 4'b0101;
    localparam logic [3:0] COND_HI   = 4'b0110;
    localparam logic [3:0] COND_CC   = 4'b0111;
    localparam logic [3:0] COND_CS   = 4'b1000;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [2:0] {IDLE, READ, EXEC, MEM, WB} state_t;

    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] fl);
        logic n, z, c, v;
        n = fl[FLAG_N];
        z = fl[FLAG_Z];
        c = fl[FLAG_C];
        v = fl[FLAG_V];
        case (cond)
            COND_AL:   return 1'b1;
            COND_EQ:   return z;
            COND_GT:   return !z && (n == v);
            COND_LTNE: return !z && (n != v);
            COND_GE:   return n == v;
            COND_LT:   return n != v;
            COND_HI:   return !z && c;
            COND_CC:   return !c;
            COND_CS:   return c;
            default:   return 1'b1;
        endcase
    endfunction

    function automatic logic writes_rf(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_MOV, OP_LSL, OP_ROR, OP_LDR};
    endfunction

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDR) || (op == OP_STR);
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Loadable up-counter bounding a memory access.
//   clk, reset (async, active-low)
//   load : clear count to zero (takes priority over en)
//   en   : advance count by one
//   tc   : count has reached MAX-1
module mem_timeout_counter #(
    parameter int unsigned MAX = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tc
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    count <= '0;
        else if (load) count <= '0;
        else if (en)   count <= count + 8'd1;
    end

    assign tc = (count == 8'(MAX - 1));

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle execute controller owning the ALU.
//   instr_valid/instr_ready/instr : instruction handshake (accepted in IDLE only)
//   rf_raddr*/rf_rdata*           : operand reads, data one cycle after address
//   rf_we/rf_waddr/rf_wdata       : write-back in WB
//   alu_*                         : ALU control/operands, driven during EXEC
//   mem_*                         : LDR/STR handshake, bounded by MEM_TIMEOUT
//   flags                         : architectural NZCV
//   pc_inc                        : one pulse per retired instruction
//   err                           : sticky memory-timeout error
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [3:0]  rf_raddr1,
    output logic [3:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [3:0]  alu_cond,
    output logic [3:0]  alu_opcode,
    output logic        alu_sbit,
    output logic [2:0]  alu_srcontrol,
    output logic [15:0] alu_imvalue,
    output logic [3:0]  alu_inflags,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_outflags,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [3:0]  flags,
    output logic        pc_inc,
    output logic        err
);

    state_t      state_q, state_d;
    logic [31:0] ir;
    logic [31:0] res;
    logic [31:0] op_a, op_b;
    logic        cond_ok;
    logic        aborted;
    logic        cond_met;
    logic        mem_tc;

    logic [3:0] ir_op;
    assign ir_op    = ir[27:24];
    assign cond_met = cond_eval(ir[31:28], flags);

    mem_timeout_counter #(.MAX(MEM_TIMEOUT)) u_mem_timeout_counter (
        .clk   (clk),
        .reset (reset),
        .load  (state_q == EXEC),
        .en    (state_q == MEM),
        .tc    (mem_tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (instr_valid) state_d = READ;
            READ: state_d = EXEC;
            EXEC: state_d = (cond_met && is_mem_op(ir_op)) ? MEM : WB;
            MEM:  if (mem_ack || mem_tc) state_d = WB;
            WB:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands are captured at EXEC so the memory address/data stay stable
    // for the whole MEM phase regardless of what the register file returns.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir      <= '0;
            res     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            cond_ok <= 1'b0;
            aborted <= 1'b0;
            flags   <= '0;
            err     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (instr_valid) ir <= instr;
                EXEC: begin
                    res     <= alu_result;
                    op_a    <= rf_rdata1;
                    op_b    <= rf_rdata2;
                    cond_ok <= cond_met;
                    aborted <= 1'b0;
                    if (cond_met && (ir[23] || ir_op == OP_CMP))
                        flags <= alu_outflags;
                end
                MEM: begin
                    // ack takes precedence over a coincident timeout
                    if (mem_ack) begin
                        if (ir_op == OP_LDR) res <= mem_rdata;
                    end else if (mem_tc) begin
                        err     <= 1'b1;
                        aborted <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign instr_ready   = (state_q == IDLE);

    assign rf_raddr1     = (state_q == READ) ? ir[15:12] : '0;
    assign rf_raddr2     = (state_q == READ) ? ir[11:8]  : '0;

    assign alu_in1       = (state_q == EXEC) ? rf_rdata1 : '0;
    assign alu_in2       = (state_q == EXEC) ? rf_rdata2 : '0;
    assign alu_cond      = (state_q == EXEC) ? ir[31:28] : '0;
    assign alu_opcode    = (state_q == EXEC) ? ir_op     : '0;
    assign alu_sbit      = (state_q == EXEC) && ir[23];
    assign alu_srcontrol = (state_q == EXEC) ? ir[22:20] : '0;
    assign alu_imvalue   = (state_q == EXEC) ? ir[15:0]  : '0;
    assign alu_inflags   = (state_q == EXEC) ? flags     : '0;

    assign mem_req       = (state_q == MEM);
    assign mem_we        = (state_q == MEM) && (ir_op == OP_STR);
    assign mem_addr      = (state_q == MEM) ? op_a : '0;
    assign mem_wdata     = (state_q == MEM) ? op_b : '0;

    assign pc_inc        = (state_q == WB);
    assign rf_we         = (state_q == WB) && cond_ok && !aborted && writes_rf(ir_op);
    assign rf_waddr      = (state_q == WB) ? ir[19:16] : '0;
    assign rf_wdata      = (state_q == WB) ? res       : '0;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [3:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] alu_in1, alu_in2;
    logic [3:0]  alu_cond, alu_opcode;
    logic        alu_sbit;
    logic [2:0]  alu_srcontrol;
    logic [15:0] alu_imvalue;
    logic [3:0]  alu_inflags;
    logic [31:0] alu_result;
    logic [3:0]  alu_outflags;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [3:0]  flags;
    logic        pc_inc;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] regs [16];

    always #5 clk = ~clk;

    // register file read port: data one cycle after address
    always @(posedge clk) begin
        rf_rdata1 <= regs[rf_raddr1];
        rf_rdata2 <= regs[rf_raddr2];
    end

    alu_sequencer #(.MEM_TIMEOUT(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .rf_raddr1     (rf_raddr1),
        .rf_raddr2     (rf_raddr2),
        .rf_rdata1     (rf_rdata1),
        .rf_rdata2     (rf_rdata2),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .alu_in1       (alu_in1),
        .alu_in2       (alu_in2),
        .alu_cond      (alu_cond),
        .alu_opcode    (alu_opcode),
        .alu_sbit      (alu_sbit),
        .alu_srcontrol (alu_srcontrol),
        .alu_imvalue   (alu_imvalue),
        .alu_inflags   (alu_inflags),
        .alu_result    (alu_result),
        .alu_outflags  (alu_outflags),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .flags         (flags),
        .pc_inc        (pc_inc),
        .err           (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc(input logic [3:0] cond, input logic [3:0] op,
                                        input logic s, input logic [3:0] rd,
                                        input logic [3:0] rn, input logic [3:0] rm);
        return {cond, op, s, 3'b000, rd, rn, rm, 8'h00};
    endfunction

    // offer one instruction; returns sampled in READ
    task automatic issue(input logic [31:0] word);
        instr       = word;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    // ALU instruction: issue, present ALU response, advance to WB sample
    task automatic run_alu(input logic [31:0] word, input logic [31:0] result, input logic [3:0] oflags);
        issue(word);
        alu_result   = result;
        alu_outflags = oflags;
        step();   // EXEC
        step();   // WB
    endtask

    // count MEM cycles from the current (MEM) sample; ack on cycle ack_at (0 = never)
    task automatic run_mem(input int ack_at, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!mem_req) break;
            n++;
            mem_ack = (n == ack_at);
            step();
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) regs[i] = '0;
        reset        = 1'b0;
        instr_valid  = 1'b0;
        instr        = '0;
        alu_result   = '0;
        alu_outflags = '0;
        mem_rdata    = '0;
        mem_ack      = 1'b0;

        // reset state
        #12;
        chk("rst_flags",   32'(flags),   32'h0);
        chk("rst_err",     32'(err),     32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_pc_inc",  32'(pc_inc),  32'h0);
        chk("rst_rf_we",   32'(rf_we),   32'h0);
        reset = 1'b1;
        step();
        chk("rst_ready", 32'(instr_ready), 32'h1);

        // ADD r3 = r1 + r2, sbit=1
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        issue(enc(4'b0000, 4'b0000, 1'b1, 4'd3, 4'd1, 4'd2));
        chk("add_raddr1", 32'(rf_raddr1),   32'd1);
        chk("add_raddr2", 32'(rf_raddr2),   32'd2);
        chk("add_busy",   32'(instr_ready), 32'h0);
        alu_result   = 32'd12;
        alu_outflags = 4'b0000;
        step();
        chk("add_in1",  alu_in1,           32'd5);
        chk("add_in2",  alu_in2,           32'd7);
        chk("add_sbit", 32'(alu_sbit),     32'h1);
        chk("add_pc0",  32'(pc_inc),       32'h0);
        step();
        chk("add_we",    32'(rf_we),    32'h1);
        chk("add_waddr", 32'(rf_waddr), 32'd3);
        chk("add_wdata", rf_wdata,      32'd12);
        chk("add_pc",    32'(pc_inc),   32'h1);
        chk("add_flags", 32'(flags),    32'h0);
        step();
        chk("add_idle", 32'(instr_ready), 32'h1);
        chk("add_pc_off", 32'(pc_inc),    32'h0);

        // CMP r1, r2 with r1 = r2 = 9
        regs[1] = 32'd9;
        regs[2] = 32'd9;
        run_alu(enc(4'b0000, 4'b1000, 1'b0, 4'd6, 4'd1, 4'd2), 32'd0, 4'b0110);
        chk("cmp_we",    32'(rf_we),  32'h0);
        chk("cmp_pc",    32'(pc_inc), 32'h1);
        chk("cmp_flags", 32'(flags),  32'h6);
        step();

        // ADDEQ r5 with Z=1: writes, flags untouched (sbit=0)
        run_alu(enc(4'b0001, 4'b0000, 1'b0, 4'd5, 4'd1, 4'd2), 32'd18, 4'b0000);
        chk("addeq_we",    32'(rf_we),    32'h1);
        chk("addeq_waddr", 32'(rf_waddr), 32'd5);
        chk("addeq_wdata", rf_wdata,      32'd18);
        chk("addeq_flags", 32'(flags),    32'h6);
        step();

        // cond 0011 with Z=1 fails: no write, no flag update, still retires
        run_alu(enc(4'b0011, 4'b0000, 1'b1, 4'd7, 4'd1, 4'd2), 32'd18, 4'b1111);
        chk("addne_we",    32'(rf_we),  32'h0);
        chk("addne_pc",    32'(pc_inc), 32'h1);
        chk("addne_flags", 32'(flags),  32'h6);
        step();

        // LDR r4 <- [r1=0x100], ack on third MEM cycle
        regs[1]   = 32'h100;
        regs[2]   = 32'h55;
        mem_rdata = 32'hDEADBEEF;
        issue(enc(4'b0000, 4'b1001, 1'b0, 4'd4, 4'd1, 4'd2));
        step();   // EXEC
        step();   // MEM 1
        chk("ldr_we_mem", 32'(mem_we),   32'h0);
        chk("ldr_addr",   mem_addr,      32'h100);
        run_mem(3, n);
        chk("ldr_ncyc",  n,             32'd3);
        chk("ldr_we",    32'(rf_we),    32'h1);
        chk("ldr_waddr", 32'(rf_waddr), 32'd4);
        chk("ldr_wdata", rf_wdata,      32'hDEADBEEF);
        chk("ldr_pc",    32'(pc_inc),   32'h1);
        step();

        // STR with ack on the timeout cycle: ack wins, no error
        regs[1] = 32'h200;
        regs[2] = 32'hCAFE;
        issue(enc(4'b0000, 4'b1010, 1'b0, 4'd8, 4'd1, 4'd2));
        step();
        step();
        chk("str_we_mem", 32'(mem_we),    32'h1);
        chk("str_wdata",  mem_wdata,      32'hCAFE);
        run_mem(16, n);
        chk("strtie_ncyc", n,             32'd16);
        chk("strtie_err",  32'(err),      32'h0);
        chk("strtie_we",   32'(rf_we),    32'h0);
        step();

        // STR with no ack: times out after 16 cycles
        issue(enc(4'b0000, 4'b1010, 1'b0, 4'd8, 4'd1, 4'd2));
        step();
        step();
        run_mem(0, n);
        chk("strto_ncyc", n,           32'd16);
        chk("strto_we",   32'(rf_we),  32'h0);
        chk("strto_pc",   32'(pc_inc), 32'h1);
        chk("strto_err",  32'(err),    32'h1);
        step();
        chk("strto_idle", 32'(instr_ready), 32'h1);
        chk("strto_err2", 32'(err),         32'h1);

        // prior flags 0100 via CMP, then SUB sbit=0 with negative result
        run_alu(enc(4'b0000, 4'b1000, 1'b0, 4'd0, 4'd1, 4'd2), 32'd0, 4'b0100);
        chk("cmp2_flags", 32'(flags), 32'h4);
        step();
        run_alu(enc(4'b0000, 4'b0001, 1'b0, 4'd9, 4'd1, 4'd2), 32'hFFFF_FFFF, 4'b1000);
        chk("sub_we",    32'(rf_we),  32'h1);
        chk("sub_wdata", rf_wdata,    32'hFFFF_FFFF);
        chk("sub_flags", 32'(flags),  32'h4);
        step();

        // reset during MEM of a load
        regs[1] = 32'h300;
        issue(enc(4'b0000, 4'b1001, 1'b0, 4'd4, 4'd1, 4'd2));
        step();
        step();
        chk("rmem_req", 32'(mem_req), 32'h1);
        reset = 1'b0;
        #1;
        chk("rmem_req_off", 32'(mem_req), 32'h0);
        chk("rmem_flags",   32'(flags),   32'h0);
        chk("rmem_err",     32'(err),     32'h0);
        chk("rmem_we",      32'(rf_we),   32'h0);
        step();
        chk("rmem_pc",      32'(pc_inc),  32'h0);
        reset = 1'b1;
        #2;
        chk("rmem_ready", 32'(instr_ready), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rmem_post_we",  32'(rf_we),   32'h0);
            chk("rmem_post_req", 32'(mem_req), 32'h0);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
